// File: rtl/fu_sequencer.sv
// fu_sequencer: single-issue valid/ready sequencer for the 8-bit add/sub/mul/and/or/xor units
module fu_sequencer #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [2:0] op;
  logic [7:0] a, b, res;
  logic ill;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (in_valid && in_ready) ? EXEC : IDLE;
      EXEC:    state_nx = (cnt == 4'd0) ? DONE : EXEC;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE) && !rst;
    busy      = state != IDLE;
  end
  // the latched operands feed every unit; op only selects which result is captured
  always_comb begin
    ill = op[2] & op[1];
    res = op == 3'd0 ? a + b :
          op == 3'd1 ? a - b :
          op == 3'd2 ? 8'(a * b) :
          op == 3'd3 ? a & b :
          op == 3'd4 ? a | b :
          op == 3'd5 ? a ^ b : 8'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      out_data <= '0;
      out_err <= 1'b0;
      op_count <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        op <= in_op;
        a <= in_a;
        b <= in_b;
        cnt <= (in_op == 3'd2) ? MUL_N : 4'd0;
      end
      if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == EXEC && cnt == 4'd0) begin
        out_data <= res;
        out_err <= ill;
      end
      if (state == DONE && out_ready) op_count <= op_count + 1'b1;
    end
endmodule

// File: tb/tb_fu_sequencer.sv
// tb_fu_sequencer: directed checks on three sequencer instances (MUL_CYCLES 3/1/15, CNT_W 16/16/4)
module tb_fu_sequencer;
  logic clk = 0, rst = 1;
  logic [2:0] iv = '0, ir, ov, oerr, bsy, ordy = '1;
  logic [2:0][2:0] iop = '0;
  logic [2:0][7:0] ia = '0, ib = '0, od;
  logic [15:0] oc0, oc1;
  logic [3:0] oc2;
  int checks = 0, errors = 0, cnt0 = 0, lat, bc, seen;
  always #5 clk = ~clk;
  fu_sequencer u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(iop[0]),
    .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .out_err(oerr[0]), .busy(bsy[0]), .op_count(oc0));
  fu_sequencer #(.MUL_CYCLES(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_op(iop[1]), .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_err(oerr[1]), .busy(bsy[1]), .op_count(oc1));
  fu_sequencer #(.MUL_CYCLES(15), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]),
    .in_ready(ir[2]), .in_op(iop[2]), .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]), .out_err(oerr[2]), .busy(bsy[2]), .op_count(oc2));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] model(logic [2:0] o, logic [7:0] x, logic [7:0] y);
    logic [15:0] p;
    p = x * y;
    case (o)
      3'd0: return {1'b0, 8'(x + y)};
      3'd1: return {1'b0, 8'(x - y)};
      3'd2: return {1'b0, p[7:0]};
      3'd3: return {1'b0, x & y};
      3'd4: return {1'b0, x | y};
      3'd5: return {1'b0, x ^ y};
      default: return 9'h100;
    endcase
  endfunction
  task automatic send(int i, logic [2:0] o, logic [7:0] x, logic [7:0] y);
    int n = 0;
    @(negedge clk);
    iv[i] = 1; iop[i] = o; ia[i] = x; ib[i] = y;
    while (!ir[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 iv[i] = 0;
  endtask
  task automatic wait_resp(int i, output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1 l++;
    end while (!ov[i] && l < 100);
    if (!ov[i]) chk("resp_timeout", 0, 1);
  endtask
  task automatic consume();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", ir, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_count", oc0, 0);
    chk("rst_data", od[0], 0);
    @(negedge clk) rst = 0;
    #1 chk("ready_after_rst", ir, 3'b111);
    // add
    send(0, 0, 200, 100);
    wait_resp(0, lat);
    chk("add_lat", lat, 1);
    chk("add_data", od[0], 44);
    chk("add_err", oerr[0], 0);
    chk("add_no_overlap", ir[0], 0);
    consume(); cnt0++;
    chk("add_count", oc0, cnt0);
    chk("add_ready_back", ir[0], 1);
    chk("add_valid_drop", ov[0], 0);
    // multiply latency on all three widths
    send(0, 2, 16, 17);
    wait_resp(0, lat);
    chk("mul3_lat", lat, 3);
    chk("mul3_data", od[0], 8'h10);
    consume(); cnt0++;
    send(0, 2, 16, 17);
    bc = 0;
    repeat (20) begin
      if (bsy[0]) bc++;
      @(posedge clk);
      #1;
    end
    cnt0++;
    chk("mul3_busy", bc, 4);
    chk("mul3_count", oc0, cnt0);
    send(1, 2, 16, 17);
    wait_resp(1, lat);
    chk("mul1_lat", lat, 1);
    chk("mul1_data", od[1], 8'h10);
    consume();
    send(2, 2, 16, 17);
    wait_resp(2, lat);
    chk("mul15_lat", lat, 15);
    chk("mul15_data", od[2], 8'h10);
    consume();
    // back-pressure with a waiting xor
    ordy[0] = 0;
    send(0, 1, 5, 7);
    wait_resp(0, lat);
    @(negedge clk);
    iv[0] = 1; iop[0] = 5; ia[0] = 8'hF0; ib[0] = 8'h3C;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", od[0], 8'hFE);
      chk("bp_valid", ov[0], 1);
      chk("bp_ready", ir[0], 0);
    end
    ordy[0] = 1;
    consume(); cnt0++;
    chk("bp_ready_back", ir[0], 1);
    @(posedge clk);
    #1 iv[0] = 0;
    chk("bp_xor_taken", bsy[0], 1);
    wait_resp(0, lat);
    chk("xor_data", od[0], 8'hCC);
    consume(); cnt0++;
    chk("bp_count", oc0, cnt0);
    // illegal opcodes
    for (int o = 6; o < 8; o++) begin
      send(0, 3'(o), 8'h55, 8'h66);
      wait_resp(0, lat);
      chk("ill_lat", lat, 1);
      chk("ill_data", od[0], 0);
      chk("ill_err", oerr[0], 1);
      consume(); cnt0++;
      chk("ill_count", oc0, cnt0);
    end
    send(0, 3, 8'hAA, 8'h0F);
    wait_resp(0, lat);
    chk("and_data", od[0], 8'h0A);
    chk("and_err", oerr[0], 0);
    consume(); cnt0++;
    // reset during EXEC, then during DONE
    send(0, 2, 3, 4);
    chk("exec_busy", bsy[0], 1);
    #2 rst = 1;
    #1 chk("rx_valid", ov[0], 0);
    chk("rx_busy", bsy[0], 0);
    chk("rx_count", oc0, 0);
    chk("rx_ready", ir[0], 0);
    @(negedge clk) rst = 0;
    cnt0 = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0] || bsy[0]) seen++;
    end
    chk("rx_no_resp", seen, 0);
    ordy[0] = 0;
    send(0, 2, 3, 4);
    wait_resp(0, lat);
    chk("rd_valid_before", ov[0], 1);
    #2 rst = 1;
    #1 chk("rd_valid", ov[0], 0);
    chk("rd_busy", bsy[0], 0);
    chk("rd_count", oc0, 0);
    chk("rd_data", od[0], 0);
    @(negedge clk) rst = 0;
    ordy[0] = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0] || bsy[0]) seen++;
    end
    chk("rd_no_resp", seen, 0);
    send(0, 4, 8'h81, 8'h18);
    wait_resp(0, lat);
    chk("or_data", od[0], 8'h99);
    consume();
    chk("or_count", oc0, 1);
    // 4-bit counter wrap against the reference model
    chk("wrap_start", oc2, 0);
    for (int k = 1; k <= 17; k++) begin
      logic [2:0] o;
      logic [7:0] x, y;
      logic [8:0] e;
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = 8'($urandom);
      e = model(o, x, y);
      send(2, o, x, y);
      wait_resp(2, lat);
      chk("rnd_lat", lat, o == 3'd2 ? 15 : 1);
      chk("rnd_data", od[2], e[7:0]);
      chk("rnd_err", oerr[2], e[8]);
      consume();
      chk("rnd_count", oc2, k % 16);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
